// File: rtl/eth_tx_frame_gen.sv
// AXI-Stream Ethernet frame source for the 1G MAC TX path (no FCS; the MAC appends it).
// Frames carry fixed MACs/EtherType, a 16-bit sequence number and a counting payload.
module eth_tx_frame_gen #(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int unsigned MIN_LEN   = 60,
    parameter int unsigned MAX_LEN   = 1514
) (
    input  logic        clock125,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] frame_count,
    input  logic [10:0] frame_len,
    input  logic [7:0]  gap_cycles,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tkeep,
    output logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    output logic        busy,
    output logic [31:0] frames_sent
);

    localparam logic [10:0]  MIN_L = 11'(MIN_LEN);
    localparam logic [10:0]  MAX_L = 11'(MAX_LEN);
    localparam logic [111:0] HDR   = {DST_MAC, SRC_MAC, ETHERTYPE};

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        GAP
    } state_t;

    state_t      state, state_next;
    logic [10:0] idx;
    logic [10:0] len;
    logic [10:0] len_clamped;
    logic [15:0] count_lat;
    logic [15:0] run_cnt;
    logic [15:0] run_next;
    logic [15:0] seq;
    logic [7:0]  gap_left;
    logic        done_pending;
    logic        done_now;
    logic        beat;
    logic        last_beat;
    logic        load_frame;
    logic [3:0]  hidx;
    logic [10:0] pay_off;
    logic [7:0]  byte_sel;

    always_comb begin
        if (frame_len < MIN_L)
            len_clamped = MIN_L;
        else if (frame_len > MAX_L)
            len_clamped = MAX_L;
        else
            len_clamped = frame_len;
    end

    assign tx_axis_tvalid = (state == FRAME);
    assign tx_axis_tlast  = tx_axis_tvalid && (idx == len - 11'd1);
    assign tx_axis_tdata  = tx_axis_tvalid ? byte_sel : '0;
    assign tx_axis_tkeep  = 1'b1;
    assign tx_axis_tuser  = 1'b0;
    assign busy           = (state != IDLE);

    assign beat      = tx_axis_tvalid && tx_axis_tready;
    assign last_beat = beat && tx_axis_tlast;
    assign run_next  = run_cnt + 16'd1;
    assign done_now  = stop || ((count_lat != '0) && (run_next == count_lat));

    // Header bytes are picked out of one concatenated constant, MSB byte first.
    always_comb begin
        hidx    = (idx < 11'd14) ? idx[3:0] : 4'd13;
        pay_off = idx - 11'd16;
        if (idx < 11'd14)
            byte_sel = HDR[{4'd13 - hidx, 3'b000} +: 8];
        else if (idx == 11'd14)
            byte_sel = seq[15:8];
        else if (idx == 11'd15)
            byte_sel = seq[7:0];
        else
            byte_sel = seq[7:0] + pay_off[7:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !stop)
                    state_next = FRAME;
            end
            FRAME: begin
                if (last_beat) begin
                    if (gap_cycles != '0)
                        state_next = GAP;
                    else if (done_now)
                        state_next = IDLE;
                    else
                        state_next = FRAME;
                end
            end
            GAP: begin
                if (gap_left == 8'd1)
                    state_next = (done_pending || stop) ? IDLE : FRAME;
            end
            default: state_next = IDLE;
        endcase
        load_frame = (state_next == FRAME) && ((state != FRAME) || last_beat);
    end

    always_ff @(posedge clock125 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            len          <= MIN_L;
            count_lat    <= '0;
            run_cnt      <= '0;
            seq          <= '0;
            gap_left     <= '0;
            done_pending <= 1'b0;
            frames_sent  <= '0;
        end else begin
            state <= state_next;

            if (load_frame) begin
                idx <= '0;
                len <= len_clamped;
            end else if (beat) begin
                idx <= idx + 11'd1;
            end

            if (state == IDLE && state_next == FRAME) begin
                count_lat <= frame_count;
                run_cnt   <= '0;
            end else if (last_beat) begin
                run_cnt <= run_next;
            end

            // done is decided at the last beat, but a stop seen during the gap still ends the run.
            if (last_beat) begin
                frames_sent  <= frames_sent + 32'd1;
                seq          <= seq + 16'd1;
                gap_left     <= gap_cycles;
                done_pending <= done_now;
            end else if (state == GAP) begin
                gap_left <= gap_left - 8'd1;
                if (stop)
                    done_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Directed bench for eth_tx_frame_gen: a reference frame model fills a scoreboard queue
// that a negedge monitor drains on each handshake; gaps, stalls and counters are checked too.
module tb_eth_tx_frame_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] frame_count = '0;
    logic [10:0] frame_len = '0;
    logic [7:0]  gap_cycles = '0;
    logic [7:0]  tdata;
    logic        tkeep;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tlast;
    logic        tuser;
    logic        busy;
    logic [31:0] frames_sent;

    eth_tx_frame_gen dut (
        .clock125      (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .frame_count   (frame_count),
        .frame_len     (frame_len),
        .gap_cycles    (gap_cycles),
        .tx_axis_tdata (tdata),
        .tx_axis_tkeep (tkeep),
        .tx_axis_tvalid(tvalid),
        .tx_axis_tready(tready),
        .tx_axis_tlast (tlast),
        .tx_axis_tuser (tuser),
        .busy          (busy),
        .frames_sent   (frames_sent)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [8:0]  sb[$];
    int          gaps[$];
    logic [15:0] model_seq = '0;
    logic [31:0] exp_frames = '0;

    int          beat_idx = 0;
    int          last_frame_beats = 0;
    int          gap_cnt = 0;
    logic        after_last = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header from literal byte table, then seq, then counting payload.
    task automatic push_frame(input int n);
        logic [111:0] hdr;
        logic [7:0]   b;
        hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
        for (int i = 0; i < n; i++) begin
            if (i < 14)
                b = hdr[111 - 8*i -: 8];
            else if (i == 14)
                b = model_seq[15:8];
            else if (i == 15)
                b = model_seq[7:0];
            else
                b = 8'((int'(model_seq[7:0]) + (i - 16)) % 256);
            sb.push_back({(i == n - 1), b});
        end
        model_seq++;
        exp_frames++;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            beat_idx   = 0;
            after_last = 1'b0;
            gap_cnt    = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, tvalid}, 32'd1);
                check("stall_data", {24'd0, tdata}, {24'd0, prev_data});
                check("stall_last", {31'd0, tlast}, {31'd0, prev_last});
            end
            if (tvalid && after_last) begin
                gaps.push_back(gap_cnt);
                after_last = 1'b0;
            end
            if (tvalid && tready) begin
                check("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    check($sformatf("beat%0d_data", beat_idx), {24'd0, tdata}, {24'd0, e[7:0]});
                    check($sformatf("beat%0d_last", beat_idx), {31'd0, tlast}, {31'd0, e[8]});
                end
                beat_idx++;
                if (tlast) begin
                    last_frame_beats = beat_idx;
                    beat_idx   = 0;
                    after_last = 1'b1;
                    gap_cnt    = 0;
                end
            end
            if (!tvalid && after_last && busy)
                gap_cnt++;
            if (!busy)
                after_last = 1'b0;
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        gaps.delete();
        model_seq  = '0;
        exp_frames = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start_run(input logic [10:0] len, input logic [15:0] cnt, input logic [7:0] gap);
        @(posedge clk); #1;
        frame_len   = len;
        frame_count = cnt;
        gap_cycles  = gap;
        start       = 1'b1;
        @(negedge clk);
        check("pre_start_valid", {31'd0, tvalid}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_latency_valid", {31'd0, tvalid}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input logic rnd, input string tag);
        logic went_idle;
        went_idle = 1'b0;
        for (int c = 0; c < budget && !went_idle; c++) begin
            @(posedge clk); #1;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!busy)
                went_idle = 1'b1;
        end
        tready = 1'b1;
        check({tag, "_idle_in_budget"}, {31'd0, went_idle}, 32'd1);
        check({tag, "_sb_drained"}, sb.size(), 32'd0);
        check({tag, "_frames_sent"}, frames_sent, exp_frames);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tdata", {24'd0, tdata}, 32'd0);
        check("rst_frames", frames_sent, 32'd0);
        check("tkeep_const", {31'd0, tkeep}, 32'd1);
        check("tuser_const", {31'd0, tuser}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: minimum frame, single shot
        push_frame(60);
        start_run(11'd60, 16'd1, 8'd0);
        wait_idle(200, 1'b0, "t1");
        check("t1_beats", last_frame_beats, 32'd60);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // 2: clamping at both ends
        push_frame(60);
        start_run(11'd10, 16'd1, 8'd0);
        wait_idle(200, 1'b0, "t2a");
        check("t2a_beats", last_frame_beats, 32'd60);
        push_frame(1514);
        start_run(11'd2000, 16'd1, 8'd0);
        wait_idle(3000, 1'b0, "t2b");
        check("t2b_beats", last_frame_beats, 32'd1514);

        // start together with stop in IDLE is ignored
        @(posedge clk); #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("start_stop_busy", {31'd0, busy}, 32'd0);
        check("start_stop_valid", {31'd0, tvalid}, 32'd0);

        // 3: random backpressure, three back-to-back frames from a fresh reset
        apply_reset();
        check("t3_rst_frames", frames_sent, 32'd0);
        for (int f = 0; f < 3; f++)
            push_frame(100);
        start_run(11'd100, 16'd3, 8'd0);
        wait_idle(2000, 1'b1, "t3");
        check("t3_gap_count", gaps.size(), 32'd2);
        while (gaps.size() > 0)
            check("t3_no_bubble", gaps.pop_front(), 32'd0);

        // 4: five idle cycles between frames
        push_frame(60);
        push_frame(60);
        start_run(11'd60, 16'd2, 8'd5);
        wait_idle(400, 1'b0, "t4");
        check("t4_gap_count", gaps.size(), 32'd1);
        if (gaps.size() > 0)
            check("t4_gap_len", gaps.pop_front(), 32'd5);

        // 5: endless run ended by stop mid-frame
        push_frame(80);
        start_run(11'd80, 16'd0, 8'd0);
        repeat (20) @(posedge clk);
        #1 stop = 1'b1;
        wait_idle(400, 1'b0, "t5");
        repeat (5) @(negedge clk);
        check("t5_no_more_valid", {31'd0, tvalid}, 32'd0);
        stop = 1'b0;

        // 6: async reset at byte 30 aborts the frame and clears counters
        push_frame(100);
        start_run(11'd100, 16'd1, 8'd0);
        begin
            logic reached;
            reached = 1'b0;
            for (int c = 0; c < 200 && !reached; c++) begin
                @(negedge clk); #1;
                if (beat_idx >= 30)
                    reached = 1'b1;
            end
            check("t6_reached_byte30", {31'd0, reached}, 32'd1);
        end
        #1 reset = 1'b1;
        #1;
        check("t6_async_tvalid", {31'd0, tvalid}, 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        gaps.delete();
        model_seq  = '0;
        exp_frames = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_frames_cleared", frames_sent, 32'd0);
        check("t6_valid_after_release", {31'd0, tvalid}, 32'd0);
        push_frame(60);
        start_run(11'd60, 16'd1, 8'd0);
        wait_idle(200, 1'b0, "t6");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
